// File: rtl/bargraph_scan.sv
// Multiplexed RGB bar-graph scan driver. A frame buffer of BITS-bit intensities is
// scanned row by row with binary-weighted bit-plane PWM: each slot (row, plane) is
// shifted out serially, latched inside a blanking window, then displayed for a time
// proportional to the plane weight while the following slot shifts in.
module bargraph_scan #(
    parameter int unsigned ROWS      = 16,
    parameter int unsigned COLS      = 30,
    parameter int unsigned BITS      = 4,
    parameter int unsigned SCLK_DIV  = 2,
    parameter int unsigned BASE_TIME = 128,
    parameter int unsigned BLANK_GAP = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     wr_en,
    input  logic [$clog2(ROWS)-1:0]  wr_row,
    input  logic [$clog2(COLS)-1:0]  wr_col,
    input  logic [BITS-1:0]          wr_data,
    output logic                     blank,
    output logic [$clog2(ROWS)-1:0]  row,
    output logic                     col,
    output logic                     sclk,
    output logic                     latch,
    output logic                     frame_start
);

    localparam int unsigned RowW     = $clog2(ROWS);
    localparam int unsigned ColW     = $clog2(COLS);
    localparam int unsigned PlaneW   = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int unsigned AddrW    = $clog2(ROWS * COLS);
    localparam int unsigned PhW      = (SCLK_DIV > 1) ? $clog2(2 * SCLK_DIV) : 1;
    localparam int unsigned GapW     = $clog2(BLANK_GAP);
    localparam int unsigned BaseMax  = BASE_TIME << (BITS - 1);
    localparam int unsigned ShiftLen = COLS * 2 * SCLK_DIV;
    localparam int unsigned MaxLen   = (BaseMax > ShiftLen) ? BaseMax : ShiftLen;
    // One spare bit so a display stretched by a slow shift cannot wrap.
    localparam int unsigned DispW    = $clog2(MaxLen + 1) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StSwitch,
        StDisplay
    } state_e;

    function automatic logic [AddrW-1:0] addr_of(input logic [RowW-1:0] r,
                                                 input logic [ColW-1:0] c);
        return AddrW'(r) * AddrW'(COLS) + AddrW'(c);
    endfunction

    // ------------------------------------------------------------------
    // Frame buffer
    // ------------------------------------------------------------------
    logic [BITS-1:0]  mem [ROWS*COLS];
    logic             wr_ok;
    logic [AddrW-1:0] wr_addr;

    assign wr_ok   = wr_en && (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
    assign wr_addr = addr_of(wr_row, wr_col);

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [GapW-1:0]    gap_q, gap_d;
    logic [DispW-1:0]   disp_cnt_q, disp_cnt_d;
    logic [RowW-1:0]    row_q, row_d;
    logic [PlaneW-1:0]  disp_plane_q, disp_plane_d;
    logic [RowW-1:0]    sh_row_q, sh_row_d;
    logic [PlaneW-1:0]  sh_plane_q, sh_plane_d;

    logic               sh_busy_q;
    logic [PhW-1:0]     sh_phase_q;
    logic [ColW-1:0]    sh_idx_q;
    logic               sclk_q;
    logic               col_q;

    logic               sh_start;
    logic               sh_last;
    logic               sh_done;
    logic [ColW-1:0]    rd_col;
    logic [BITS-1:0]    rd_word;
    logic               rd_bit;
    logic [DispW-1:0]   disp_len;
    logic [DispW-1:0]   disp_last;

    // ------------------------------------------------------------------
    // Shift engine: COLS bits, column COLS-1 first, each bit = one sclk period
    // ------------------------------------------------------------------
    // The read address always points at the column the next col update needs.
    assign rd_col  = (sh_start || (sh_idx_q == '0)) ? ColW'(COLS - 1) : sh_idx_q - ColW'(1);
    assign rd_word = mem[addr_of(sh_row_q, rd_col)];
    assign rd_bit  = rd_word[sh_plane_q];

    assign sh_last = sh_busy_q && (sh_phase_q == PhW'(2 * SCLK_DIV - 1)) && (sh_idx_q == '0);
    assign sh_done = !sh_busy_q || sh_last;

    // Serializer: col updates on entry to the low phase, sclk high for the second half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_busy_q  <= 1'b0;
            sh_phase_q <= '0;
            sh_idx_q   <= '0;
            sclk_q     <= 1'b0;
            col_q      <= 1'b0;
        end else if (sh_start) begin
            sh_busy_q  <= 1'b1;
            sh_phase_q <= '0;
            sh_idx_q   <= ColW'(COLS - 1);
            sclk_q     <= 1'b0;
            col_q      <= rd_bit;
        end else if (sh_busy_q) begin
            if (sh_phase_q == PhW'(2 * SCLK_DIV - 1)) begin
                sclk_q     <= 1'b0;
                sh_phase_q <= '0;
                if (sh_idx_q == '0) begin
                    sh_busy_q <= 1'b0;
                    col_q     <= 1'b0;
                end else begin
                    sh_idx_q <= sh_idx_q - ColW'(1);
                    col_q    <= rd_bit;
                end
            end else begin
                sh_phase_q <= sh_phase_q + PhW'(1);
                if (sh_phase_q == PhW'(SCLK_DIV - 1)) begin
                    sclk_q <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan sequencer
    // ------------------------------------------------------------------
    assign disp_len  = DispW'(BASE_TIME) << disp_plane_q;
    assign disp_last = disp_len - DispW'(1);

    // State and slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            gap_q        <= '0;
            disp_cnt_q   <= '0;
            row_q        <= '0;
            disp_plane_q <= '0;
            sh_row_q     <= '0;
            sh_plane_q   <= '0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            disp_cnt_q   <= disp_cnt_d;
            row_q        <= row_d;
            disp_plane_q <= disp_plane_d;
            sh_row_q     <= sh_row_d;
            sh_plane_q   <= sh_plane_d;
        end
    end

    // Next-state logic and blank/latch/frame_start decode.
    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        disp_cnt_d   = disp_cnt_q;
        row_d        = row_q;
        disp_plane_d = disp_plane_q;
        sh_row_d     = sh_row_q;
        sh_plane_d   = sh_plane_q;
        sh_start     = 1'b0;
        blank        = 1'b1;
        latch        = 1'b0;
        frame_start  = 1'b0;

        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d  = StPrime;
                    sh_start = 1'b1;
                end
            end

            StPrime: begin
                if (sh_last) begin
                    state_d = StSwitch;
                    gap_d   = '0;
                end
            end

            StSwitch: begin
                latch = (gap_q == GapW'(1));
                if (gap_q == GapW'(2)) begin
                    // Shifted slot becomes the displayed one; shifter moves on.
                    row_d        = sh_row_q;
                    disp_plane_d = sh_plane_q;
                    if (sh_plane_q == PlaneW'(BITS - 1)) begin
                        sh_plane_d = '0;
                        sh_row_d   = (sh_row_q == RowW'(ROWS - 1)) ? '0 : sh_row_q + RowW'(1);
                    end else begin
                        sh_plane_d = sh_plane_q + PlaneW'(1);
                    end
                end
                if (gap_q == GapW'(BLANK_GAP - 1)) begin
                    state_d    = StDisplay;
                    disp_cnt_d = '0;
                    sh_start   = 1'b1;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end

            StDisplay: begin
                blank       = 1'b0;
                frame_start = (disp_cnt_q == '0) && (row_q == '0) && (disp_plane_q == '0);
                disp_cnt_d  = disp_cnt_q + DispW'(1);
                // Display stretches until the concurrent shift has also finished.
                if ((disp_cnt_q >= disp_last) && sh_done) begin
                    gap_d   = '0;
                    state_d = enable ? StSwitch : StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign row  = row_q;
    assign col  = col_q;
    assign sclk = sclk_q;

endmodule

// File: tb/tb_bargraph_scan.sv
// Directed bench for bargraph_scan with a slot scoreboard: expected slot contents are
// queued from a frame-buffer model as stimulus is issued and checked at each latch.
module tb_bargraph_scan;

    localparam int ROWS  = 16;
    localparam int COLS  = 30;
    localparam int BITS  = 4;
    localparam int BASE  = 128;
    localparam int FRAME = 30976;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_row = '0;
    logic [4:0] wr_col = '0;
    logic [3:0] wr_data = '0;
    logic       blank;
    logic [3:0] row;
    logic       col;
    logic       sclk;
    logic       latch;
    logic       frame_start;

    bargraph_scan #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .BITS      (BITS),
        .SCLK_DIV  (2),
        .BASE_TIME (BASE),
        .BLANK_GAP (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .blank       (blank),
        .row         (row),
        .col         (col),
        .sclk        (sclk),
        .latch       (latch),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]      row;
        logic [1:0]      plane;
        logic [COLS-1:0] bits;
    } slot_t;

    slot_t           exp_q[$];
    slot_t           pend;
    logic [3:0]      model [ROWS][COLS];
    logic [COLS-1:0] shreg = '0;

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   edges = 0;
    int   dlen = 0;
    int   last_fs = 0;
    int   latch_cnt = 0;
    int   n, falls, lc0;
    logic pend_valid = 1'b0;
    logic in_disp = 1'b0;
    logic fs_valid = 1'b0;
    logic prev_sclk = 1'b0;
    logic prev_blank = 1'b1;
    logic edge_chk_en = 1'b1;
    logic b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    // Advance to the next falling clock edge and run the output monitor there.
    task automatic tick();
        slot_t cur;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            edges      = 0;
            pend_valid = 1'b0;
            in_disp    = 1'b0;
            fs_valid   = 1'b0;
            prev_sclk  = 1'b0;
            prev_blank = 1'b1;
            return;
        end
        if (sclk && !prev_sclk) begin
            shreg = {shreg[COLS-2:0], col};
            edges++;
        end
        if (latch) begin
            latch_cnt++;
            if (edge_chk_en) chk("sclk_edges_per_slot", edges, COLS);
            edges = 0;
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                chk($sformatf("slot_bits_r%0d_p%0d", cur.row, cur.plane), shreg, cur.bits);
                pend       = cur;
                pend_valid = 1'b1;
            end
        end
        if (prev_blank && !blank) begin
            in_disp = 1'b1;
            dlen    = 0;
            if (pend_valid) chk("display_row", row, pend.row);
        end
        if (!blank) dlen++;
        if (!prev_blank && blank && in_disp) begin
            in_disp = 1'b0;
            if (pend_valid) chk($sformatf("display_len_p%0d", pend.plane), dlen, BASE << pend.plane);
            pend_valid = 1'b0;
        end
        if (frame_start) begin
            chk("frame_start_row", row, 0);
            if (fs_valid) chk("frame_period", cyc - last_fs, FRAME);
            fs_valid = 1'b1;
            last_fs  = cyc;
        end
        prev_sclk  = sclk;
        prev_blank = blank;
    endtask

    task automatic wr(input int r, input int c, input int d);
        wr_en   = 1'b1;
        wr_row  = r[3:0];
        wr_col  = c[4:0];
        wr_data = d[3:0];
        tick();
        wr_en = 1'b0;
        if (c < COLS) model[r][c] = d[3:0];
    endtask

    task automatic push_slot(input int r, input int p);
        slot_t s;
        s.row   = r[3:0];
        s.plane = p[1:0];
        for (int c = 0; c < COLS; c++) s.bits[c] = model[r][c][p];
        exp_q.push_back(s);
    endtask

    task automatic chk_reset_outputs(input string pre);
        chk({pre, "_blank"}, blank, 1);
        chk({pre, "_row"}, row, 0);
        chk({pre, "_col"}, col, 0);
        chk({pre, "_sclk"}, sclk, 0);
        chk({pre, "_latch"}, latch, 0);
        chk({pre, "_frame_start"}, frame_start, 0);
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_blank", blank, 1);
        chk("idle_sclk", sclk, 0);

        // Clear the frame buffer, one lit entry, one out-of-range write
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wr(r, c, 0);
        wr(3, 7, 4'hA);
        wr(2, 31, 4'hF);

        // Expected slots: all of frame 0 and frame 1 up to row 5 plane 2
        for (int r = 0; r < ROWS; r++)
            for (int p = 0; p < BITS; p++) push_slot(r, p);
        for (int s = 0; s <= 22; s++) push_slot(s / BITS, s % BITS);

        // Start scanning
        enable = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!latch && n < 300);
        chk("first_latch_cycle", n, 122);
        do begin tick(); n++; end while (blank && n < 300);
        chk("first_blank_fall_cycle", n, 125);
        chk("first_display_row", row, 0);
        chk("first_frame_start", frame_start, 1);

        // Second frame start (period checked by the monitor)
        n = 0;
        do begin tick(); n++; end while (!frame_start && n < FRAME + 100);
        chk("second_frame_start_seen", frame_start, 1);

        // Advance to display of row 5 plane 2
        falls = 0;
        n = 0;
        while (falls < 22 && n < 20000) begin
            b0 = blank;
            tick();
            n++;
            if (b0 && !blank) falls++;
        end
        chk("reach_row5_plane2", falls, 22);
        chk("row5_displayed", row, 5);

        // Drop enable mid-display: slot completes, then blank and row hold
        repeat (100) tick();
        enable = 1'b0;
        n = 0;
        while (!blank && n < 2000) begin tick(); n++; end
        chk("stop_blank_rises", blank, 1);
        lc0 = latch_cnt;
        repeat (400) tick();
        chk("stop_no_latch", latch_cnt - lc0, 0);
        chk("stop_row_held", row, 5);
        chk("stop_blank_held", blank, 1);

        // Re-enable: PRIME of the next slot (row 5 plane 3)
        push_slot(5, 3);
        edge_chk_en = 1'b0;
        enable = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!latch && n < 300);
        chk("restart_latch_cycle", n, 122);
        tick();
        edge_chk_en = 1'b1;

        // Reset in the middle of the next shift
        n = 0;
        while (!sclk && n < 300) begin tick(); n++; end
        chk("mid_shift_sclk_high", sclk, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        repeat (3) tick();
        push_slot(0, 0);
        push_slot(0, 1);
        push_slot(0, 2);
        push_slot(0, 3);
        push_slot(1, 0);
        rst_n = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 5000) begin tick(); n++; end
        repeat (10) tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
